// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU opcode constants and sequencer state encoding for the
// shift-and-add MUL sequencer that borrows the EX-stage ALU.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] FUNC_ADD = 4'b0000;

  localparam logic [1:0] BT_EQ = 2'b00;
  localparam logic [1:0] BT_NE = 2'b01;
  localparam logic [1:0] BT_GE = 2'b10;
  localparam logic [1:0] BT_LT = 2'b11;

  // alu_op is {FuncCode, btype}; the ALU ignores btype for ADD
  localparam logic [5:0] ALU_OP_ADD = {FUNC_ADD, BT_EQ};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// RV32M MUL (low word) via shift-and-add, time-sharing the EX-stage ALU
// for the accumulate step and stalling the pipeline while busy.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [data_width-1:0] req_a,
  input  logic [data_width-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [data_width-1:0] resp_result,
  output logic                  busy,
  output logic                  alu_own,
  output logic [5:0]            alu_op,
  output logic [data_width-1:0] alu_a,
  output logic [data_width-1:0] alu_b,
  input  logic [data_width-1:0] alu_c
);

  localparam int unsigned CNT_W = $clog2(data_width);

  seq_state_e state, state_next;

  logic [data_width-1:0] acc;
  logic [data_width-1:0] mcand;
  logic [data_width-1:0] mplr;
  logic [CNT_W-1:0]      cnt;
  logic                  zero_operand;
  logic                  run_last;

  always_comb begin
    zero_operand = (req_a == '0) || (req_b == '0);
    // stop once no multiplier bits remain above the one consumed this cycle
    run_last = (mplr[data_width-1:1] == '0) ||
               (cnt == CNT_W'(data_width - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    alu_own     = 1'b0;
    alu_op      = ALU_OP_ADD;
    alu_a       = '0;
    alu_b       = '0;
    resp_valid  = 1'b0;
    resp_result = '0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_next = zero_operand ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        alu_own = 1'b1;
        alu_a   = acc;
        alu_b   = mcand;
        if (run_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        resp_valid  = 1'b1;
        resp_result = acc;
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            acc   <= '0;
            mcand <= req_a;
            mplr  <= req_b;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (mplr[0]) begin
            acc <= alu_c;
          end
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: directed cases with literal expectations plus random
// traffic checked every cycle against a timing/arithmetic model.
module tb_alu_mul_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_result;
  logic         busy;
  logic         alu_own;
  logic [5:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_c;

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer #(.data_width(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .busy(busy),
    .alu_own(alu_own), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // stand-in for the EX-stage ALU performing ADD
  assign alu_c = alu_a + alu_b;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int top_bit(input logic [W-1:0] v);
    int k = 0;
    for (int i = 0; i < int'(W); i++) if (v[i]) k = i + 1;
    return k;
  endfunction

  // Model: an accepted request spends k cycles owning the ALU (k = MSB index
  // of b plus one, zero if either operand is zero), then offers a*b until taken.
  bit           m_busy = 1'b0;
  logic [W-1:0] m_a, m_b;
  int           m_k, m_n;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1;
        m_a = req_a;
        m_b = req_b;
        m_n = 1;
        m_k = (req_a == '0) ? 0 : top_bit(req_b);
      end
    end else if (m_n > m_k && resp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_n++;
    end
  end

  logic         e_run;
  logic [W-1:0] e_mask, e_alu_a, e_alu_b, e_res;

  always @(negedge clk) begin
    if (!m_busy) begin
      chk("idle_req_ready", W'(req_ready), W'(1));
      chk("idle_busy", W'(busy), '0);
      chk("idle_alu_own", W'(alu_own), '0);
      chk("idle_resp_valid", W'(resp_valid), '0);
      chk("idle_resp_result", resp_result, '0);
      chk("idle_alu_a", alu_a, '0);
      chk("idle_alu_b", alu_b, '0);
    end else begin
      e_run   = (m_n <= m_k);
      e_alu_a = '0;
      e_alu_b = '0;
      e_res   = '0;
      if (e_run) begin
        e_mask  = (W'(1) << (m_n - 1)) - W'(1);
        e_alu_a = m_a * (m_b & e_mask);
        e_alu_b = m_a << (m_n - 1);
      end else begin
        e_res = m_a * m_b;
      end
      chk("busy_req_ready", W'(req_ready), '0);
      chk("busy_busy", W'(busy), W'(1));
      chk("alu_own", W'(alu_own), W'(e_run));
      chk("resp_valid", W'(resp_valid), W'(!e_run));
      chk("resp_result", resp_result, e_res);
      chk("alu_a", alu_a, e_alu_a);
      chk("alu_b", alu_b, e_alu_b);
    end
    chk("alu_op", W'(alu_op), '0);
  end

  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int exp_lat, input int hold);
    int lat = 0;
    int own = 0;
    bit found = 0;
    @(posedge clk); #2;
    req_valid = 1'b1; req_a = a; req_b = b; resp_ready = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0;
    for (int i = 1; i <= 60 && !found; i++) begin
      @(negedge clk);
      if (alu_own) own++;
      if (resp_valid) begin
        found = 1;
        lat = i;
      end
    end
    chk("latency", W'(lat), W'(exp_lat));
    chk("run_cycles", W'(own), W'(exp_lat - 1));
    chk("result_literal", resp_result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", W'(resp_valid), W'(1));
      chk("hold_result", resp_result, exp_res);
      chk("hold_busy", W'(busy), W'(1));
      chk("hold_req_ready", W'(req_ready), '0);
    end
    #1 resp_ready = 1'b1;
    @(posedge clk); #2;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_req_ready", W'(req_ready), W'(1));
    chk("idle_after_busy", W'(busy), '0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit found;
    int lat;

    repeat (3) @(negedge clk);
    chk("reset_req_ready", W'(req_ready), W'(1));
    chk("reset_resp_valid", W'(resp_valid), '0);
    chk("reset_busy", W'(busy), '0);
    #1 reset = 1'b0;

    run_req(32'd3, 32'd5, 32'd15, 4, 0);
    run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0);
    run_req(32'h1234, 32'd0, 32'd0, 1, 0);
    run_req(32'd0, 32'd7, 32'd0, 1, 0);
    run_req(32'd6, 32'd7, 32'd42, 4, 5);

    // asynchronous reset in the 4th RUN cycle
    @(posedge clk); #2;
    req_valid = 1'b1; req_a = 32'h10; req_b = 32'h8000_0000;
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_own", W'(alu_own), W'(1));
    #1 reset = 1'b1;
    #1;
    chk("async_rst_req_ready", W'(req_ready), W'(1));
    chk("async_rst_busy", W'(busy), '0);
    chk("async_rst_alu_own", W'(alu_own), '0);
    chk("async_rst_resp_valid", W'(resp_valid), '0);
    chk("async_rst_result", resp_result, '0);
    chk("async_rst_alu_a", alu_a, '0);
    chk("async_rst_alu_b", alu_b, '0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    run_req(32'd2, 32'd9, 32'd18, 5, 0);

    // back-to-back: second request waits, held valid, behind the first
    @(posedge clk); #2;
    req_valid = 1'b1; req_a = 32'd7; req_b = 32'd8; resp_ready = 1'b1;
    @(posedge clk); #2;
    req_a = 32'h10000; req_b = 32'h10000;
    found = 0; lat = 0;
    for (int i = 1; i <= 60 && !found; i++) begin
      @(negedge clk);
      if (resp_valid) begin found = 1; lat = i; end
    end
    chk("b2b_first_lat", W'(lat), W'(5));
    chk("b2b_first_result", resp_result, 32'd56);
    @(negedge clk);
    chk("b2b_gap_req_ready", W'(req_ready), W'(1));
    @(posedge clk); #2;
    req_valid = 1'b0;
    found = 0; lat = 0;
    for (int i = 1; i <= 60 && !found; i++) begin
      @(negedge clk);
      if (resp_valid) begin found = 1; lat = i; end
    end
    chk("b2b_second_lat", W'(lat), W'(18));
    chk("b2b_second_result", resp_result, 32'd0);
    @(posedge clk); #2;
    resp_ready = 1'b0;

    // random traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) ra = '0;
      if ($urandom_range(0, 9) == 0) rb = '0;
      req_valid  = ($urandom_range(0, 9) < 7);
      req_a      = ra;
      req_b      = rb;
      resp_ready = ($urandom_range(0, 1) == 1);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", W'(busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle shift-and-add multiplier controller that time-shares the EX-stage ALU to implement RV32M MUL (low 32 bits of the product). When the pipeline issues a MUL, this block takes ownership of the ALU, drives it with ADD operations, and stalls the pipeline. When the result is ready, it presents it through a valid/ready response handshake and releases the ALU. It sits beside the ALU in EX. The pipeline muxes the ALU inputs from this block whenever `alu_own` is high.

## Interface
- `data_width`, 32, operand/result width (power of two, ≥ 8)
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `req_valid`  in  1  MUL request from EX
- `req_ready`  out  1  high only in IDLE
- `req_a`  in  data_width  multiplicand
- `req_b`  in  data_width  multiplier
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  consumer accepts result
- `resp_result`  out  data_width  (req_a × req_b) mod 2^data_width
- `busy`  out  1  state ≠ IDLE; drives pipeline stall
- `alu_own`  out  1  high in RUN; the pipeline must route `alu_op`/`alu_a`/`alu_b` below to the ALU
- `alu_op`  out  6  {FuncCode, btype}; constant ADD = 6'b000000; bcond ignored
- `alu_a`  out  data_width  accumulator
- `alu_b`  out  data_width  shifted multiplicand
- `alu_c`  in  data_width  ALU result (combinational, same cycle)

## Operation
- **Registers:**
  - `acc`, `mcand`, `mplr` (data_width each)
  - `cnt` ($clog2(data_width) bits)
  - `state` ∈ {IDLE, RUN, DONE}
- **Reset:**
  - state=IDLE; acc, mcand, mplr, cnt = 0.
  - Outputs: req_ready=1, resp_valid=0, resp_result=0, busy=0, alu_own=0, alu_op=0, alu_a=0, alu_b=0.
- **IDLE:**
  - req_ready=1. On req_valid: mcand←req_a, mplr←req_b, acc←0, cnt←0.
  - If req_a==0 or req_b==0, go to DONE (fast path). Otherwise go to RUN.
- **RUN, each cycle:**
  - alu_own=1, alu_a=acc, alu_b=mcand.
  - If mplr[0], acc←alu_c; otherwise acc holds.
  - mcand←mcand<<1; mplr←mplr>>1; cnt←cnt+1.
  - Go to DONE when (mplr>>1)==0 or cnt==data_width−1. Otherwise stay in RUN.
- **DONE:**
  - resp_valid=1, resp_result=acc, held stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE.
- **Outputs outside RUN:** alu_own=0, alu_a=0, alu_b=0, alu_op=ADD.
- **Arithmetic:** all wrap modulo 2^data_width. Signedness is irrelevant for the low word; no overflow flag.
- **Ignored inputs:** req_valid outside IDLE (req_ready=0). resp_ready outside DONE.

## Timing
- Request accepted at edge t (IDLE, req_valid).
- k = index of MSB of req_b + 1 (1..data_width).
- RUN occupies cycles t+1 … t+k, and resp_valid rises in cycle t+k+1.
- Fast path: resp_valid in cycle t+1.
- Worst case (req_b[MSB]=1): resp_valid at t+data_width+1.
- req_ready returns high the cycle after the response handshake. There is no same-cycle response-to-request bypass, so minimum spacing between accepts is k+2 cycles.
- busy is high from cycle t+1 through the handshake cycle.
- Reset asserted mid-RUN or mid-DONE: immediately (asynchronously) return to reset values. Any in-flight result is discarded and no resp_valid is emitted.
- ALU path is combinational: alu_a/alu_b → alu_c must close within one cycle alongside the EX mux.

## Structure
- Shared package/header (`opcodes.v` include):
  - ALU FuncCode constant FUNC_ADD = 4'b0000 and btype constants (EQ/NE/GE/LT), so `alu_op` encoding matches the ALU.
  - Sequencer state encodings IDLE/RUN/DONE (2 bits).
- Single module, no sub-modules. The ALU itself is instantiated in EX, not inside this block.

## Test plan
- **Basic:** a=3, b=5 → exactly 3 RUN cycles with alu_own=1, resp_valid at t+4, resp_result=15; alu_c accepted only on b bits 0 and 2.
- **Wrap:** a=0xFFFFFFFF, b=0xFFFFFFFF → 32 RUN cycles, resp_valid at t+33, resp_result=0x00000001.
- **Zero fast path:** a=0x1234, b=0 → no RUN cycle (alu_own stays 0), resp_valid at t+1, resp_result=0. Same for a=0, b=7.
- **Backpressure:** a=6, b=7 with resp_ready low for 5 cycles → resp_valid and resp_result=42 held stable, busy=1, req_ready=0 throughout. Release → IDLE next cycle.
- **Reset mid-operation:** a=0x10, b=0x80000000, reset asserted in 4th RUN cycle → all outputs at reset values without waiting for a clock edge. After deassert, a=2, b=9 → 18.
- **Back-to-back:** second request held valid during the first → accepted in the first IDLE cycle after the handshake, and both results are correct (e.g. 7×8=56 then 0x10000×0x10000=0).
